// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: double-dabble binary-to-BCD converter feeding a 4-digit multiplexed common-anode scanner
module display_scan_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_conv_done,
  output logic [3:0]            o_bcd,
  output logic                  o_digit_en,
  output logic [3:0]            o_an,
  output logic [1:0]            o_digit_sel
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = $clog2(REFRESH_DIV);
  typedef enum logic {IDLE, CONV} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [15:0]           scratch_q, scratch_d, adj;
  logic [15:0]           disp_q, disp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [PW-1:0]         presc_q;
  logic [1:0]            idx_q;
  logic [3:0]            nz;
  logic                  last;
  assign last = cnt_q == CW'(1);
  for (genvar g = 0; g < 4; g++) begin : g_nib
    assign adj[4*g +: 4] = scratch_q[4*g +: 4] >= 4'd5 ? scratch_q[4*g +: 4] + 4'd3 : scratch_q[4*g +: 4];
    assign nz[g]         = |disp_q[4*g +: 4];
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (i_load ? CONV : IDLE) : (last ? IDLE : CONV);
  end
  always_comb begin
    o_busy = state_q == CONV;
    done_d = state_q == CONV && last;
  end
  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    if (state_q == IDLE && i_load) begin
      shift_d   = i_value;
      scratch_d = '0;
      cnt_d     = CW'(DATA_WIDTH);
    end else if (state_q == CONV) begin
      {scratch_d, shift_d} = {adj, shift_q} << 1;
      cnt_d                = cnt_q - CW'(1);
      // the final shift lands directly in the display, skipping a copy cycle
      if (last) disp_d = scratch_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      done_q    <= done_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end
  always_comb begin
    o_conv_done = done_q;
    o_digit_sel = idx_q;
    o_an        = ~(4'b0001 << idx_q);
    o_bcd       = disp_q[{idx_q, 2'b00} +: 4];
    o_digit_en  = (idx_q == 2'd0) | (|(nz >> idx_q));
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: checks two configurations against a decimal-arithmetic reference model
module tb_display_scan_ctrl;
  logic        clk, rst, load_a, load_b;
  logic [7:0]  val_a;
  logic [12:0] val_b;
  logic        busy [2];
  logic        done [2];
  logic        en   [2];
  logic [3:0]  bcd  [2];
  logic [3:0]  an   [2];
  logic [1:0]  sel  [2];
  int n_assert = 0, n_fail = 0;
  int mbusy [2], pend [2], mdisp [2], mcyc [2];
  bit mdone [2];

  display_scan_ctrl #(.DATA_WIDTH(8), .REFRESH_DIV(4)) u_a (
    .i_clk(clk), .i_reset(rst), .i_value(val_a), .i_load(load_a),
    .o_busy(busy[0]), .o_conv_done(done[0]), .o_bcd(bcd[0]), .o_digit_en(en[0]),
    .o_an(an[0]), .o_digit_sel(sel[0]));
  display_scan_ctrl #(.DATA_WIDTH(13), .REFRESH_DIV(3)) u_b (
    .i_clk(clk), .i_reset(rst), .i_value(val_b), .i_load(load_b),
    .o_busy(busy[1]), .o_conv_done(done[1]), .o_bcd(bcd[1]), .o_digit_en(en[1]),
    .o_an(an[1]), .o_digit_sel(sel[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int dw(int u);
    return u ? 13 : 8;
  endfunction
  function automatic int rd(int u);
    return u ? 3 : 4;
  endfunction

  // model: a load starts a DATA_WIDTH-cycle busy window, the value appears as decimal digits after it
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      mdone[u] = 0;
      if (rst) begin
        mbusy[u] = 0;
        mdisp[u] = 0;
        mcyc[u]  = 0;
      end else begin
        mcyc[u]++;
        if (mbusy[u] > 0) begin
          mbusy[u]--;
          if (mbusy[u] == 0) begin
            mdisp[u] = pend[u];
            mdone[u] = 1;
          end
        end else if (u ? load_b : load_a) begin
          mbusy[u] = dw(u);
          pend[u]  = u ? int'(val_b) : int'(val_a);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < 2; u++) begin
      int k, p;
      string s;
      s = u ? "b" : "a";
      k = (mcyc[u] / rd(u)) % 4;
      p = 1;
      for (int j = 0; j < k; j++) p *= 10;
      chk({s, ".busy"}, 32'(busy[u]), 32'(mbusy[u] > 0));
      chk({s, ".done"}, 32'(done[u]), 32'(mdone[u]));
      chk({s, ".sel"},  32'(sel[u]),  32'(k));
      chk({s, ".an"},   32'(an[u]),   32'(15 ^ (1 << k)));
      chk({s, ".bcd"},  32'(bcd[u]),  32'((mdisp[u] / p) % 10));
      chk({s, ".en"},   32'(en[u]),   32'(k == 0 || mdisp[u] >= p));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic load_value_a(input logic [7:0] v, input int wait_cycles);
    val_a  = v;
    load_a = 1;
    step();
    load_a = 0;
    repeat (wait_cycles) step();
  endtask

  initial begin
    rst = 1; load_a = 0; load_b = 0; val_a = 0; val_b = 0;
    step();
    rst = 0;
    repeat (20) step();
    load_value_a(8'd255, 30);
    load_value_a(8'd100, 30);
    load_value_a(8'd37, 2);
    val_a  = 8'd99;
    load_a = 1;
    step();
    load_a = 0;
    repeat (25) step();
    load_value_a(8'd99, 30);
    load_value_a(8'd200, 3);
    rst = 1;
    step();
    rst = 0;
    repeat (5) step();
    val_b  = 13'd8191;
    load_b = 1;
    step();
    load_b = 0;
    repeat (30) step();
    repeat (500) begin
      load_a = $urandom_range(0, 5) == 0;
      val_a  = 8'($urandom);
      load_b = $urandom_range(0, 5) == 0;
      val_b  = 13'($urandom);
      rst    = $urandom_range(0, 99) == 0;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
